// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampled UART receiver, LSB first, one start and SB_TICKS/16 stop bits
module uart_rx #(
   parameter int DATA_BITS = 8,
   parameter int SB_TICKS  = 16
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 TICK,
   input  logic                 RX,
   output logic [DATA_BITS-1:0] DATA_OUT,
   output logic                 RX_DONE,
   output logic                 FRAME_ERR
);

   localparam int S_MAX = (SB_TICKS > 16) ? SB_TICKS : 16;
   localparam int S_W   = $clog2(S_MAX);
   localparam int N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state, state_nx;
   logic [S_W-1:0]       s, s_nx;
   logic [N_W-1:0]       n, n_nx;
   logic [DATA_BITS-1:0] b, b_nx;
   logic [DATA_BITS-1:0] data_nx;
   logic                 done_nx, err_nx;
   logic                 rx_meta, rx_s;

   // State register, datapath registers and the two-flop RX synchronizer
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         s         <= '0;
         n         <= '0;
         b         <= '0;
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         DATA_OUT  <= '0;
         RX_DONE   <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         state     <= state_nx;
         s         <= s_nx;
         n         <= n_nx;
         b         <= b_nx;
         rx_meta   <= RX;
         rx_s      <= rx_meta;
         DATA_OUT  <= data_nx;
         RX_DONE   <= done_nx;
         FRAME_ERR <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      s_nx     = s;
      n_nx     = n;
      b_nx     = b;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nx = START;
               s_nx     = '0;
            end
         end
         START: begin
            if (TICK) begin
               if (s == S_W'(7)) begin
                  // Line must still be low at mid start bit, otherwise treat it as a glitch
                  if (!rx_s) begin
                     state_nx = DATA;
                     s_nx     = '0;
                     n_nx     = '0;
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  s_nx = s + 1'b1;
               end
            end
         end
         DATA: begin
            if (TICK) begin
               if (s == S_W'(15)) begin
                  s_nx = '0;
                  b_nx = {rx_s, b[DATA_BITS-1:1]};
                  if (n == N_W'(DATA_BITS-1)) state_nx = STOP;
                  else                        n_nx = n + 1'b1;
               end else begin
                  s_nx = s + 1'b1;
               end
            end
         end
         STOP: begin
            if (TICK) begin
               if (s == S_W'(SB_TICKS-1)) state_nx = IDLE;
               else                       s_nx = s + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      done_nx = 1'b0;
      data_nx = DATA_OUT;
      err_nx  = FRAME_ERR;
      if (state == STOP && TICK && s == S_W'(SB_TICKS-1)) begin
         done_nx = 1'b1;
         data_nx = b;
         err_nx  = ~rx_s;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with TICK every 4 CLK
module tb_uart_rx;

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       TICK = 1'b0;
   logic       RX = 1'b1;
   logic [7:0] DATA_OUT;
   logic       RX_DONE;
   logic       FRAME_ERR;

   int checks = 0;
   int failures = 0;
   int tick_total = 0;
   int tick_cnt = 0;
   bit tick_en = 1'b1;

   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   int         got_t[$];

   uart_rx #(.DATA_BITS(8), .SB_TICKS(16)) dut (
      .CLK(CLK), .reset(reset), .TICK(TICK), .RX(RX),
      .DATA_OUT(DATA_OUT), .RX_DONE(RX_DONE), .FRAME_ERR(FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (tick_en && tick_cnt == 3) begin
            TICK = 1'b1;
            tick_total++;
         end else begin
            TICK = 1'b0;
         end
         tick_cnt = (tick_cnt + 1) % 4;
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         if (RX_DONE === 1'b1) begin
            got_q.push_back({FRAME_ERR, DATA_OUT});
            got_t.push_back(tick_total);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "timeout");
   end

   task automatic wait_ticks(input int k);
      repeat (k) begin
         @(posedge CLK);
         while (TICK !== 1'b1) @(posedge CLK);
      end
   endtask

   task automatic line(input logic v, input int k);
      #1 RX = v;
      wait_ticks(k);
   endtask

   // Start bit, LSB-first data, then 16 ticks of stop; a low stop bit is
   // released after 12 ticks so the receiver does not restart on it.
   task automatic send_frame(input logic [7:0] d, input bit stop, input int pause_bit);
      line(1'b0, 16);
      for (int i = 0; i < 8; i++) begin
         if (i == pause_bit) begin
            line(d[i], 8);
            tick_en = 1'b0;
            repeat (1000) @(posedge CLK);
            tick_en = 1'b1;
            wait_ticks(8);
         end else begin
            line(d[i], 16);
         end
      end
      if (stop) begin
         line(1'b1, 16);
      end else begin
         line(1'b0, 12);
         line(1'b1, 4);
      end
      exp_q.push_back({~stop, d});
   endtask

   task automatic test_reset();
      @(negedge CLK);
      checks++;
      if (DATA_OUT !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", DATA_OUT); end
      checks++;
      if (RX_DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", RX_DONE); end
      checks++;
      if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", FRAME_ERR); end
      reset = 1'b1;
      wait_ticks(4);
   endtask

   task automatic test_glitch();
      line(1'b0, 4);
      line(1'b1, 40);
      checks++;
      if (got_q.size() != 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", got_q.size()); end
      checks++;
      if (DATA_OUT !== 8'h00) begin failures++; $display("FAIL glitch_data got=%h exp=00", DATA_OUT); end
      got_q.delete(); got_t.delete();
   endtask

   task automatic test_basic();
      send_frame(8'hA5, 1'b1, -1);
      line(1'b1, 20);
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [8:0] g, e;
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (g !== e) begin failures++; $display("FAIL basic_frame got=%h exp=%h", g, e); end
      end
      checks++;
      if (DATA_OUT !== 8'hA5) begin failures++; $display("FAIL basic_hold got=%h exp=a5", DATA_OUT); end
      exp_q.delete(); got_q.delete(); got_t.delete();
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b0, -1);
      line(1'b1, 20);
      send_frame(8'h81, 1'b1, -1);
      line(1'b1, 20);
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ferr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [8:0] g, e;
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (g !== e) begin failures++; $display("FAIL ferr_frame got=%h exp=%h", g, e); end
      end
      exp_q.delete(); got_q.delete(); got_t.delete();
   endtask

   task automatic test_back_to_back();
      send_frame(8'h00, 1'b1, -1);
      send_frame(8'hFF, 1'b1, -1);
      line(1'b1, 20);
      checks++;
      if (got_q.size() != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
      if (got_t.size() == 2) begin
         checks++;
         if (got_t[1] - got_t[0] != 160) begin failures++; $display("FAIL b2b_spacing got=%0d exp=160", got_t[1] - got_t[0]); end
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [8:0] g, e;
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (g !== e) begin failures++; $display("FAIL b2b_frame got=%h exp=%h", g, e); end
      end
      exp_q.delete(); got_q.delete(); got_t.delete();
   endtask

   task automatic test_reset_abort();
      line(1'b0, 16);
      line(1'b0, 16);
      line(1'b0, 16);
      line(1'b0, 16);
      line(1'b0, 8);
      #3 reset = 1'b0;
      RX = 1'b1;
      #1;
      checks++;
      if (DATA_OUT !== 8'h00) begin failures++; $display("FAIL abort_data got=%h exp=00", DATA_OUT); end
      checks++;
      if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL abort_err got=%b exp=0", FRAME_ERR); end
      repeat (10) @(negedge CLK);
      checks++;
      if (RX_DONE !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", RX_DONE); end
      reset = 1'b1;
      line(1'b1, 200);
      checks++;
      if (got_q.size() != 0) begin failures++; $display("FAIL abort_pulses got=%0d exp=0", got_q.size()); end
      got_q.delete(); got_t.delete();
      send_frame(8'h55, 1'b1, -1);
      line(1'b1, 20);
      checks++;
      if (got_q.size() != 1) begin failures++; $display("FAIL abort_next_count got=%0d exp=1", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [8:0] g, e;
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (g !== e) begin failures++; $display("FAIL abort_next_frame got=%h exp=%h", g, e); end
      end
      exp_q.delete(); got_q.delete(); got_t.delete();
   endtask

   task automatic test_tick_hold();
      send_frame(8'h5A, 1'b1, 3);
      line(1'b1, 20);
      checks++;
      if (got_q.size() != 1) begin failures++; $display("FAIL hold_count got=%0d exp=1", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [8:0] g, e;
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (g !== e) begin failures++; $display("FAIL hold_frame got=%h exp=%h", g, e); end
      end
      exp_q.delete(); got_q.delete(); got_t.delete();
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_basic();
      test_frame_err();
      test_back_to_back();
      test_reset_abort();
      test_tick_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
